// File: rtl/dct_col_sched.sv
// Column scheduler for the col_dct engine: ping-pong row buffer, transposed column
// issue, and a credit-protected FWFT result FIFO (the engine itself cannot stall).
module dct_col_sched #(
   parameter int DCT_LAT     = 5,
   parameter int OFIFO_DEPTH = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [63:0]  i_row,
   output logic         o_dct_valid,
   output logic [63:0]  o_dct_data,
   input  logic         i_dct_valid,
   input  logic [87:0]  i_dct_data,
   output logic         o_valid,
   input  logic         i_out_ready,
   output logic [87:0]  o_data,
   output logic [2:0]   o_col,
   output logic         o_last,
   output logic         o_busy,
   output logic         o_ovf
);
   localparam int CW = $clog2(OFIFO_DEPTH) + 1;
   localparam int AW = $clog2(OFIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_CR = CW'(OFIFO_DEPTH);
   localparam logic [CW-1:0] BLK_CR   = CW'(8);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   generate
      if (OFIFO_DEPTH < 8 || (OFIFO_DEPTH & (OFIFO_DEPTH - 1)) != 0 || DCT_LAT < 1) begin : g_bad_param
         $error("dct_col_sched: OFIFO_DEPTH must be a power of 2 >= 8, DCT_LAT >= 1");
      end
   endgenerate

   logic [63:0]   r_mem [2][8];
   logic [1:0]    r_full;
   logic          r_wr_bank, r_rd_bank;
   logic [2:0]    r_wr_row, r_col;
   logic [0:0]    r_state;
   logic [CW-1:0] r_credits;
   logic          r_dct_valid;
   logic [63:0]   r_dct_data;

   logic [90:0]   r_fifo [OFIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_rcol;
   logic          r_ovf;

   logic          w_accept, w_fill_done, w_start, w_chain, w_release, w_load, w_deduct;
   logic [1:0]    w_set, w_clr;
   logic [63:0]   w_col_data;
   logic          w_ffull, w_push, w_pop;
   logic [90:0]   w_head;

   assign o_ready     = !r_full[r_wr_bank];
   assign w_accept    = i_valid && o_ready;
   assign w_fill_done = w_accept && (r_wr_row == 3'd7);

   // r_col sits at 0 whenever the FSM is idle, so a start always reads column 0
   assign w_start   = (r_state == S_IDLE) && r_full[r_rd_bank] && (r_credits >= BLK_CR);
   assign w_release = (r_state == S_ISSUE) && (r_col == 3'd7);
   assign w_chain   = w_release && r_full[~r_rd_bank] && (r_credits >= BLK_CR);
   assign w_load    = w_start || (r_state == S_ISSUE);
   assign w_deduct  = w_start || w_chain;

   assign w_set = {w_fill_done && r_wr_bank, w_fill_done && !r_wr_bank};
   assign w_clr = {w_release && r_rd_bank, w_release && !r_rd_bank};

   // Transpose on read: row r of the column comes from pixel r_col of stored row r
   genvar g;
   generate
      for (g = 0; g < 8; g++) begin : g_col
         assign w_col_data[8*g +: 8] = r_mem[r_rd_bank][g][{r_col, 3'b000} +: 8];
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (w_accept) r_mem[r_wr_bank][r_wr_row] <= i_row;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_full      <= 2'b00;
         r_wr_bank   <= 1'b0;
         r_rd_bank   <= 1'b0;
         r_wr_row    <= 3'd0;
         r_col       <= 3'd0;
         r_state     <= S_IDLE;
         r_credits   <= DEPTH_CR;
         r_dct_valid <= 1'b0;
         r_dct_data  <= 64'd0;
      end else begin
         if (w_accept)    r_wr_row  <= r_wr_row + 3'd1;
         if (w_fill_done) r_wr_bank <= ~r_wr_bank;
         r_full <= (r_full & ~w_clr) | w_set;
         r_dct_valid <= w_load;
         if (w_load) begin
            r_dct_data <= w_col_data;
            r_col      <= r_col + 3'd1;
         end
         if (w_release) r_rd_bank <= ~r_rd_bank;
         if (w_start) r_state <= S_ISSUE;
         else if (w_release && !w_chain) r_state <= S_IDLE;
         r_credits <= r_credits - (w_deduct ? BLK_CR : '0) + CW'(w_pop);
      end
   end

   assign o_dct_valid = r_dct_valid;
   assign o_dct_data  = r_dct_data;

   // Result FIFO; a full FIFO drops the result and flags overflow
   assign w_ffull = (r_cnt == DEPTH_CR);
   assign w_push  = i_dct_valid && !w_ffull;
   assign o_valid = (r_cnt != '0);
   assign w_pop   = o_valid && i_out_ready;

   always_ff @(posedge i_clk) begin
      if (w_push) r_fifo[r_wptr] <= {r_rcol, i_dct_data};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         r_rcol <= 3'd0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
         if (i_dct_valid) r_rcol <= r_rcol + 3'd1;
         if (i_dct_valid && w_ffull) r_ovf <= 1'b1;
      end
   end

   assign w_head = r_fifo[r_rptr];
   assign o_data = o_valid ? w_head[87:0] : 88'd0;
   assign o_col  = o_valid ? w_head[90:88] : 3'd0;
   assign o_last = o_valid && (w_head[90:88] == 3'd7);
   assign o_ovf  = r_ovf;
   assign o_busy = (|r_full) || (r_state == S_ISSUE) || r_dct_valid ||
                   (r_credits != DEPTH_CR) || o_valid;
endmodule

// File: tb/tb_dct_col_sched.sv
// Bench for dct_col_sched: delay-line engine model, column/result scoreboards,
// table of single-block vectors plus stream, backpressure, reset and overflow sequences.
module tb_dct_col_sched;
   localparam int DCT_LAT = 5;
   localparam int DEPTH   = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_valid, o_ready;
   logic [63:0]  i_row;
   logic         o_dct_valid;
   logic [63:0]  o_dct_data;
   logic         i_dct_valid;
   logic [87:0]  i_dct_data;
   logic         o_valid, i_out_ready;
   logic [87:0]  o_data;
   logic [2:0]   o_col;
   logic         o_last, o_busy, o_ovf;

   always #5 clk = ~clk;

   dct_col_sched #(.DCT_LAT(DCT_LAT), .OFIFO_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_row(i_row),
      .o_dct_valid(o_dct_valid), .o_dct_data(o_dct_data),
      .i_dct_valid(i_dct_valid), .i_dct_data(i_dct_data),
      .o_valid(o_valid), .i_out_ready(i_out_ready), .o_data(o_data), .o_col(o_col),
      .o_last(o_last), .o_busy(o_busy), .o_ovf(o_ovf)
   );

   function automatic logic [87:0] zext(input logic [63:0] d);
      logic [87:0] z;
      z = '0;
      for (int r = 0; r < 8; r++) z[11*r +: 11] = {3'b000, d[8*r +: 8]};
      return z;
   endfunction

   function automatic logic [7:0] pix(input logic [7:0] base, input logic [7:0] rs,
                                      input logic [7:0] cs, input int r, input int c);
      int t;
      t = int'(base) + r * int'(rs) + c * int'(cs);
      return t[7:0];
   endfunction

   // Engine model: DCT_LAT-cycle passthrough, lanes zero-extended; inj_* forces extra results
   logic [DCT_LAT-1:0] eng_v;
   logic [63:0]        eng_d [DCT_LAT];
   logic               inj_v;
   logic [87:0]        inj_d;
   always @(posedge clk) begin
      if (rst) eng_v <= '0;
      else begin
         eng_v <= {eng_v[DCT_LAT-2:0], o_dct_valid};
         for (int k = DCT_LAT - 1; k > 0; k--) eng_d[k] <= eng_d[k-1];
         eng_d[0] <= o_dct_data;
      end
   end
   assign i_dct_valid = eng_v[DCT_LAT-1] | inj_v;
   assign i_dct_data  = inj_v ? inj_d : zext(eng_d[DCT_LAT-1]);

   typedef struct { logic [87:0] data; logic [2:0] col; } res_t;
   typedef struct { logic [7:0] base; logic [7:0] rstep; logic [7:0] cstep;
                    int exp_lat; logic exp_ovf; } vec_t;

   res_t        res_q[$];
   logic [63:0] dct_q[$];
   int n_chk = 0, n_fail = 0, cyc = 0;
   int dct_cnt = 0, starts = 0, pops = 0, pops_d1 = 0;
   int cur_run = 0, max_run = 0, last_acc = 0;
   logic tog_en = 1'b0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc = cyc + 1;

   always @(posedge clk) if (tog_en) #1 i_out_ready = ~i_out_ready;

   // Monitors: column stream, credit legality at each block start, result scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (o_dct_valid) begin
            if (dct_cnt % 8 == 0) begin
               check("credits_at_start", 128'((16 - 8 * starts + pops_d1) >= 8), 128'(1));
               starts++;
            end
            if (dct_q.size() == 0) check("dct_unexpected", 128'(o_dct_valid), 128'(0));
            else check("dct_column", 128'(o_dct_data), 128'(dct_q.pop_front()));
            dct_cnt++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
         end else cur_run = 0;
         pops_d1 = pops;
         if (o_valid && i_out_ready) begin
            if (res_q.size() == 0) check("result_unexpected", 128'(o_valid), 128'(0));
            else begin
               res_t e;
               e = res_q.pop_front();
               check("out_data", 128'(o_data), 128'(e.data));
               check("out_col",  128'(o_col),  128'(e.col));
               check("out_last", 128'(o_last), 128'(e.col == 3'd7));
            end
            pops++;
         end
      end
   end

   task automatic clear_model();
      res_q.delete();
      dct_q.delete();
      dct_cnt = 0; starts = 0; pops = 0; pops_d1 = 0; cur_run = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      clear_model();
   endtask

   task automatic chk_reset();
      check("rst_o_ready",     128'(o_ready),     128'(1));
      check("rst_o_dct_valid", 128'(o_dct_valid), 128'(0));
      check("rst_o_dct_data",  128'(o_dct_data),  128'(0));
      check("rst_o_valid",     128'(o_valid),     128'(0));
      check("rst_o_data",      128'(o_data),      128'(0));
      check("rst_o_col",       128'(o_col),       128'(0));
      check("rst_o_last",      128'(o_last),      128'(0));
      check("rst_o_busy",      128'(o_busy),      128'(0));
      check("rst_o_ovf",       128'(o_ovf),       128'(0));
   endtask

   // Streams n blocks back to back; block b uses base0 + 17*b
   task automatic send_blocks(input int n, input logic [7:0] base0, input logic [7:0] rs,
                              input logic [7:0] cs, output int stalls);
      stalls = 0;
      @(posedge clk); #1;
      for (int b = 0; b < n; b++) begin
         logic [7:0] base;
         base = base0 + 8'(17 * b);
         for (int r = 0; r < 8; r++) begin
            int w;
            for (int c = 0; c < 8; c++) i_row[8*c +: 8] = pix(base, rs, cs, r, c);
            i_valid = 1'b1;
            w = 0;
            do begin
               @(negedge clk);
               if (!o_ready) begin stalls++; w++; end
            end while (!o_ready && w < 2000);
            if (w >= 2000) check("accept_timeout", 128'(o_ready), 128'(1));
            last_acc = cyc;
            @(posedge clk); #1;
         end
         for (int c = 0; c < 8; c++) begin
            logic [63:0] cv;
            res_t e;
            for (int r = 0; r < 8; r++) cv[8*r +: 8] = pix(base, rs, cs, r, c);
            dct_q.push_back(cv);
            e.data = zext(cv);
            e.col  = 3'(c);
            res_q.push_back(e);
         end
      end
      i_valid = 1'b0;
   endtask

   task automatic wait_drain(input int maxc);
      int w;
      w = 0;
      while ((res_q.size() != 0 || dct_q.size() != 0) && w < maxc) begin
         @(negedge clk);
         w++;
      end
      if (w >= maxc) check("drain_timeout", 128'(res_q.size()), 128'(0));
   endtask

   vec_t tbl[4];

   initial begin
      int st, lat, p0, s0;
      tbl[0] = '{base: 8'h00, rstep: 8'h08, cstep: 8'h01, exp_lat: 2, exp_ovf: 1'b0};
      tbl[1] = '{base: 8'hF0, rstep: 8'h11, cstep: 8'h03, exp_lat: 2, exp_ovf: 1'b0};
      tbl[2] = '{base: 8'hFF, rstep: 8'h00, cstep: 8'h00, exp_lat: 2, exp_ovf: 1'b0};
      tbl[3] = '{base: 8'h5A, rstep: 8'h80, cstep: 8'h25, exp_lat: 2, exp_ovf: 1'b0};

      rst = 1'b1; i_valid = 1'b0; i_row = '0; i_out_ready = 1'b1; inj_v = 1'b0; inj_d = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset();
      @(posedge clk); #1 rst = 1'b0;

      // Isolated blocks: latency, transpose, result order, idle afterwards
      for (int i = 0; i < 4; i++) begin
         send_blocks(1, tbl[i].base, tbl[i].rstep, tbl[i].cstep, st);
         lat = -1;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_dct_valid) begin lat = cyc - last_acc; break; end
         end
         check("issue_latency", 128'(lat), 128'(tbl[i].exp_lat));
         check("busy_active", 128'(o_busy), 128'(1));
         wait_drain(100);
         repeat (2) @(negedge clk);
         check("vec_ovf", 128'(o_ovf), 128'(tbl[i].exp_ovf));
         check("busy_idle", 128'(o_busy), 128'(0));
      end

      // Back-to-back stream of 4 blocks
      max_run = 0; p0 = pops;
      send_blocks(4, 8'h10, 8'h08, 8'h01, st);
      check("stream_stalls", 128'(st), 128'(0));
      wait_drain(200);
      check("stream_issue_run", 128'(max_run), 128'(32));
      check("stream_results", 128'(pops - p0), 128'(32));

      // Backpressure: only two blocks may issue, the other two stay buffered
      @(posedge clk); #1 i_out_ready = 1'b0;
      p0 = pops; s0 = starts;
      send_blocks(4, 8'h33, 8'h07, 8'h0D, st);
      repeat (12) @(negedge clk);
      check("bp_ready_low", 128'(o_ready), 128'(0));
      check("bp_no_issue", 128'(o_dct_valid), 128'(0));
      check("bp_blocks_issued", 128'(starts - s0), 128'(2));
      check("bp_head_valid", 128'(o_valid), 128'(1));
      @(posedge clk); #1 i_out_ready = 1'b1;
      wait_drain(300);
      check("bp_results", 128'(pops - p0), 128'(32));
      check("bp_ovf", 128'(o_ovf), 128'(0));

      // Credit edge: downstream ready toggles every cycle
      tog_en = 1'b1; p0 = pops;
      send_blocks(4, 8'h81, 8'h09, 8'hF1, st);
      wait_drain(600);
      tog_en = 1'b0;
      @(posedge clk); #2 i_out_ready = 1'b1;
      check("toggle_results", 128'(pops - p0), 128'(32));
      check("toggle_ovf", 128'(o_ovf), 128'(0));

      // Reset while column 3 is on the engine interface
      send_blocks(1, 8'h40, 8'h08, 8'h01, st);
      lat = 0;
      while (!(o_dct_valid && dct_cnt % 8 == 3) && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      check("reach_col3", 128'(o_dct_valid), 128'(1));
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      clear_model();
      @(negedge clk);
      chk_reset();
      send_blocks(1, 8'h00, 8'h08, 8'h01, st);
      wait_drain(100);
      repeat (2) @(negedge clk);
      check("post_rst_results", 128'(pops), 128'(8));
      check("post_rst_busy", 128'(o_busy), 128'(0));

      // Overflow: 17 forced results into a 16-entry FIFO
      do_reset();
      i_out_ready = 1'b0;
      for (int k = 0; k < 17; k++) begin
         logic [95:0] t;
         res_t e;
         t = {$urandom, $urandom, $urandom};
         inj_d = t[87:0];
         inj_v = 1'b1;
         if (k < 16) begin e.data = t[87:0]; e.col = 3'(k % 8); res_q.push_back(e); end
         @(posedge clk); #1;
         if (k == 15) check("ovf_at_full", 128'(o_ovf), 128'(0));
         if (k == 16) check("ovf_on_17th", 128'(o_ovf), 128'(1));
      end
      inj_v = 1'b0;
      p0 = pops;
      i_out_ready = 1'b1;
      wait_drain(60);
      repeat (3) @(negedge clk);
      check("ovf_fifo_entries", 128'(pops - p0), 128'(16));
      check("ovf_sticky", 128'(o_ovf), 128'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
